// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and helpers for the Wishbone RAM slave.
//   resp_t     : one response-pipe stage {valid, err, data}
//   sel_merge  : byte-lane merge of a new word into an old word
// Data fields are sized for the widest supported bus (DATA_WIDTH_MAX); the
// slave zero-extends into them and truncates back out to its own DATA_WIDTH.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int LATENCY_MAX    = 8;
  localparam int DATA_WIDTH_MAX = 64;
  localparam int SEL_WIDTH_MAX  = DATA_WIDTH_MAX / 8;

  typedef struct packed {
    logic                      valid;
    logic                      err;
    logic [DATA_WIDTH_MAX-1:0] data;
  } resp_t;

  // Bytes whose sel bit is set come from new_word, the rest keep old_word.
  function automatic logic [DATA_WIDTH_MAX-1:0] sel_merge(
    input logic [DATA_WIDTH_MAX-1:0] old_word,
    input logic [DATA_WIDTH_MAX-1:0] new_word,
    input logic [SEL_WIDTH_MAX-1:0]  sel
  );
    logic [DATA_WIDTH_MAX-1:0] merged;
    merged = old_word;
    for (int b = 0; b < SEL_WIDTH_MAX; b++) begin
      if (sel[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_stall_gen.sv
// -----------------------------------------------------------------------------
// wb_stall_gen
// 16-bit rotating stall mask. The register loads STALL_PATTERN on reset and
// rotates right by one on every clock edge where advance is high; bit 0 is
// the stall request for the current cycle.
// Ports:
//   clk        in   bus clock
//   reset_n    in   asynchronous active-low reset
//   advance    in   rotate enable (driven by wb_cyc)
//   stall_pat  out  current pattern bit (pat[0])
// -----------------------------------------------------------------------------
module wb_stall_gen #(
  parameter logic [15:0] STALL_PATTERN = 16'h0000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic advance,
  output logic stall_pat
);

  logic [15:0] pat_reg;
  logic [15:0] pat_rot;
  logic [15:0] pat_next;

  // Rotate right: bit gi takes bit gi+1, bit 15 wraps from bit 0.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rot
    assign pat_rot[gi] = pat_reg[(gi + 1) % 16];
  end

  always_comb begin
    pat_next = pat_reg;
    if (advance) begin
      pat_next = pat_rot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_reg <= STALL_PATTERN;
    end else begin
      pat_reg <= pat_next;
    end
  end

  assign stall_pat = pat_reg[0];

endmodule

// File: rtl/wb_ram_slave.sv
// -----------------------------------------------------------------------------
// wb_ram_slave
// Pipelined Wishbone B4 slave backed by a word-addressed RAM. Every accepted
// request gets exactly one ACK (in range) or ERR (out of range) exactly
// LATENCY edges after its acceptance edge, in request order. STALL is driven
// from registers only: a rotating pattern plus an outstanding-request limit.
// Dropping wb_cyc flushes all pending responses.
// Ports:
//   clk        in   bus clock
//   reset_n    in   asynchronous active-low reset
//   wb_cyc     in   cycle valid
//   wb_stb     in   strobe
//   wb_we      in   write enable
//   wb_adr     in   word address [ADDR_WIDTH]
//   wb_sel     in   byte enables [DATA_WIDTH/8]
//   wb_dat_m   in   write data [DATA_WIDTH]
//   wb_stall   out  slave cannot accept this cycle
//   wb_ack     out  normal termination
//   wb_err     out  error termination
//   wb_dat_s   out  read data [DATA_WIDTH], zero unless a read ACK
// -----------------------------------------------------------------------------
module wb_ram_slave #(
  parameter int          ADDR_WIDTH      = 10,
  parameter int          DATA_WIDTH      = 32,
  parameter int          MEM_WORDS       = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] STALL_PATTERN   = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [DATA_WIDTH-1:0]   wb_dat_m,
  output logic                    wb_stall,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic [DATA_WIDTH-1:0]   wb_dat_s
);

  import wb_pkg::*;

  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  // ---------------------------------------------------------------------------
  // Stall: pattern bit OR outstanding limit reached. Registers only, so there
  // is no combinational path from the request inputs to wb_stall.
  // ---------------------------------------------------------------------------
  logic             stall_pat;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] outstanding_next;

  wb_stall_gen #(
    .STALL_PATTERN(STALL_PATTERN)
  ) u_stall_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .advance   (wb_cyc),
    .stall_pat (stall_pat)
  );

  assign wb_stall = stall_pat | (outstanding_reg == CNT_W'(MAX_OUTSTANDING));

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              in_range;
  logic [MEM_AW-1:0] mem_idx;
  logic              resp_out;

  assign accept   = wb_cyc & wb_stb & ~wb_stall;
  assign in_range = ({1'b0, wb_adr} < (ADDR_WIDTH + 1)'(MEM_WORDS));
  assign mem_idx  = wb_adr[MEM_AW-1:0];

  // ---------------------------------------------------------------------------
  // RAM: byte-enabled write at the acceptance edge, no reset on contents.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (accept && wb_we && in_range) begin
      mem[mem_idx] <= DATA_WIDTH'(sel_merge(DATA_WIDTH_MAX'(mem[mem_idx]),
                                            DATA_WIDTH_MAX'(wb_dat_m),
                                            SEL_WIDTH_MAX'(wb_sel)));
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipe. Stage 0 captures the registered RAM read at the acceptance
  // edge; the last stage drives the bus, so the master samples the response
  // LATENCY edges after acceptance. Only in-range reads carry data, which keeps
  // wb_dat_s at zero for write ACKs and ERRs without extra muxing downstream.
  // ---------------------------------------------------------------------------
  resp_t pipe_reg [LATENCY];

  assign resp_out = pipe_reg[LATENCY-1].valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
    end else if (!wb_cyc) begin
      // Abort: pending responses are discarded, committed writes stay.
      for (int i = 0; i < LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
    end else begin
      pipe_reg[0].valid <= accept;
      pipe_reg[0].err   <= accept & ~in_range;
      pipe_reg[0].data  <= (accept && !wb_we && in_range) ?
                           DATA_WIDTH_MAX'(mem[mem_idx]) : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  assign wb_ack   = pipe_reg[LATENCY-1].valid & ~pipe_reg[LATENCY-1].err;
  assign wb_err   = pipe_reg[LATENCY-1].valid &  pipe_reg[LATENCY-1].err;
  assign wb_dat_s = wb_ack ? pipe_reg[LATENCY-1].data[DATA_WIDTH-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Outstanding counter: accept and response on the same edge cancel out.
  // A response can only leave while a request is counted, and accept is
  // blocked at the limit, so the count stays within 0..MAX_OUTSTANDING.
  // ---------------------------------------------------------------------------
  always_comb begin
    outstanding_next = outstanding_reg;
    if (!wb_cyc) begin
      outstanding_next = '0;
    end else if (accept && !resp_out) begin
      outstanding_next = outstanding_reg + CNT_W'(1);
    end else if (!accept && resp_out) begin
      outstanding_next = outstanding_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_reg <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
    end
  end

endmodule
